// File: rtl/edge_raster_engine_pkg.sv
// rtl/edge_raster_engine_pkg.sv - shared types and widths for the edge-function rasterizer
// Purpose: FSM state encoding, edge-accumulator width helper, edge-coefficient record.
// Ports: none (package raster_defs).
package raster_defs;

    localparam int RD_COORD_W = 16;
    localparam int RD_DEPTH_W = 2;
    localparam int RD_COLOR_W = 16;

    // Wide enough for A*x + B*y + C with unsigned COORD_W coordinates plus sign.
    function automatic int ew_width(input int coord_w);
        return 2 * coord_w + 3;
    endfunction

    localparam int RD_EW = ew_width(RD_COORD_W);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_BBOX  = 3'd1,
        S_EDGES = 3'd2,
        S_SCAN  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    // Two's-complement A, B, C of one edge function E(x,y) = A*x + B*y + C.
    typedef struct packed {
        logic [RD_EW-1:0] a;
        logic [RD_EW-1:0] b;
        logic [RD_EW-1:0] c;
    } edge_coef_t;

endpackage

// File: rtl/edge_raster_engine_if.sv
// rtl/edge_raster_engine_if.sv - triangle-in / pixel-out handshake bundle
// Purpose: groups the triangle handshake, vertex data and pixel stream signals.
// Ports: slave modport for the engine, master modport for the producer/consumer side.
interface edge_raster_engine_if #(
    parameter int COORD_W = 16,
    parameter int DEPTH_W = 2,
    parameter int COLOR_W = 16
);
    logic               in_tri_valid;
    logic               out_tri_ready;
    logic [COORD_W-1:0] in_v0_x, in_v0_y, in_v1_x, in_v1_y, in_v2_x, in_v2_y;
    logic [DEPTH_W-1:0] in_v0_depth, in_v1_depth, in_v2_depth;
    logic [COLOR_W-1:0] in_color;
    logic               out_pix_valid;
    logic               in_pix_ready;
    logic [COORD_W-1:0] out_pixel_x, out_pixel_y;
    logic [DEPTH_W-1:0] out_pixel_depth;
    logic [COLOR_W-1:0] out_pixel_color;
    logic               out_busy;
    logic               out_tri_done;

    modport slave (
        input  in_tri_valid, in_v0_x, in_v0_y, in_v1_x, in_v1_y, in_v2_x, in_v2_y,
               in_v0_depth, in_v1_depth, in_v2_depth, in_color, in_pix_ready,
        output out_tri_ready, out_pix_valid, out_pixel_x, out_pixel_y,
               out_pixel_depth, out_pixel_color, out_busy, out_tri_done
    );

    modport master (
        output in_tri_valid, in_v0_x, in_v0_y, in_v1_x, in_v1_y, in_v2_x, in_v2_y,
               in_v0_depth, in_v1_depth, in_v2_depth, in_color, in_pix_ready,
        input  out_tri_ready, out_pix_valid, out_pixel_x, out_pixel_y,
               out_pixel_depth, out_pixel_color, out_busy, out_tri_done
    );
endinterface

// File: rtl/edge_raster_engine_edge_eval.sv
// rtl/edge_raster_engine_edge_eval.sv - one edge function: setup, step along x, row reload
// Purpose: computes A, B, C for edge i->j, loads E at (x0,y0) with optional orientation flip,
//          then steps E by A per pixel and reloads from the row-start value plus B per row.
// Ports: clock/reset; i_xi/i_yi/i_xj/i_yj edge endpoints; i_x0/i_y0 scan origin;
//        i_neg flip orientation at load; i_load/i_step_x/i_step_row controls;
//        o_c unflipped C (for area), o_e current edge value.
module raster_edge_eval
    import raster_defs::*;
#(
    parameter int COORD_W = RD_COORD_W,
    parameter int EW      = ew_width(COORD_W)
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [COORD_W-1:0]   i_xi,
    input  logic [COORD_W-1:0]   i_yi,
    input  logic [COORD_W-1:0]   i_xj,
    input  logic [COORD_W-1:0]   i_yj,
    input  logic [COORD_W-1:0]   i_x0,
    input  logic [COORD_W-1:0]   i_y0,
    input  logic                 i_neg,
    input  logic                 i_load,
    input  logic                 i_step_x,
    input  logic                 i_step_row,
    output logic signed [EW-1:0] o_c,
    output logic signed [EW-1:0] o_e
);
    logic signed [EW-1:0] w_xi, w_yi, w_xj, w_yj, w_x0, w_y0, w_e0;
    edge_coef_t           w_coef;
    logic signed [EW-1:0] r_a, r_b, r_e, r_row;

    assign w_xi = $signed({{(EW-COORD_W){1'b0}}, i_xi});
    assign w_yi = $signed({{(EW-COORD_W){1'b0}}, i_yi});
    assign w_xj = $signed({{(EW-COORD_W){1'b0}}, i_xj});
    assign w_yj = $signed({{(EW-COORD_W){1'b0}}, i_yj});
    assign w_x0 = $signed({{(EW-COORD_W){1'b0}}, i_x0});
    assign w_y0 = $signed({{(EW-COORD_W){1'b0}}, i_y0});

    always_comb begin
        w_coef.a = w_yi - w_yj;
        w_coef.b = w_xj - w_xi;
        w_coef.c = w_xi * w_yj - w_xj * w_yi;
        w_e0     = $signed(w_coef.a) * w_x0 + $signed(w_coef.b) * w_y0 + $signed(w_coef.c);
    end

    assign o_c = $signed(w_coef.c);
    assign o_e = r_e;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_a   <= '0;
            r_b   <= '0;
            r_e   <= '0;
            r_row <= '0;
        end else if (i_load) begin
            // Clockwise triangles are flipped so that "inside" is always E >= 0.
            r_a   <= i_neg ? -$signed(w_coef.a) : $signed(w_coef.a);
            r_b   <= i_neg ? -$signed(w_coef.b) : $signed(w_coef.b);
            r_e   <= i_neg ? -w_e0 : w_e0;
            r_row <= i_neg ? -w_e0 : w_e0;
        end else if (i_step_row) begin
            r_row <= r_row + r_b;
            r_e   <= r_row + r_b;
        end else if (i_step_x) begin
            r_e   <= r_e + r_a;
        end
    end
endmodule

// File: rtl/edge_raster_engine.sv
// rtl/edge_raster_engine.sv - self-sequencing edge-function triangle rasterizer
// Purpose: accepts one triangle, computes clamped bbox and edge setup, scans row-major and
//          streams covered pixels through a single back-pressured output register.
// Ports: clock, reset (sync, active-high); bus (slave): triangle handshake and vertex data in,
//        pixel stream out, busy and one-cycle tri_done pulse.
module edge_raster_engine
    import raster_defs::*;
#(
    parameter int COORD_W  = RD_COORD_W,
    parameter int DEPTH_W  = RD_DEPTH_W,
    parameter int COLOR_W  = RD_COLOR_W,
    parameter int SCREEN_W = 640,
    parameter int SCREEN_H = 480
) (
    input  logic clock,
    input  logic reset,
    edge_raster_engine_if.slave bus
);
    localparam int EW = ew_width(COORD_W);
    localparam logic [COORD_W-1:0] X_LIM = COORD_W'(SCREEN_W - 1);
    localparam logic [COORD_W-1:0] Y_LIM = COORD_W'(SCREEN_H - 1);

    function automatic logic [COORD_W-1:0] min3(input logic [COORD_W-1:0] a, b, c);
        logic [COORD_W-1:0] m;
        m = (a < b) ? a : b;
        return (m < c) ? m : c;
    endfunction

    function automatic logic [COORD_W-1:0] max3(input logic [COORD_W-1:0] a, b, c);
        logic [COORD_W-1:0] m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

    state_t                  r_state;
    logic [2:0][COORD_W-1:0] r_vx, r_vy;
    logic [DEPTH_W-1:0]      r_depth;
    logic [COLOR_W-1:0]      r_color;
    logic [COORD_W-1:0]      r_xmin, r_xmax, r_ymin, r_ymax, r_x, r_y;
    logic                    r_scan_end;
    logic                    r_pix_valid, r_tri_done;
    logic [COORD_W-1:0]      r_pix_x, r_pix_y;
    logic [DEPTH_W-1:0]      r_pix_depth;
    logic [COLOR_W-1:0]      r_pix_color;

    logic [COORD_W-1:0]   w_xmin, w_ymin, w_xmax_raw, w_ymax_raw, w_xmax, w_ymax;
    logic [DEPTH_W-1:0]   w_dmin01, w_dmin;
    logic signed [EW-1:0] w_c [3];
    logic signed [EW-1:0] w_e [3];
    logic signed [EW-1:0] w_area;
    logic w_neg, w_load, w_inside, w_scanning, w_out_free, w_advance;
    logic w_row_end, w_last, w_step_x, w_step_row;

    always_comb begin
        w_xmin     = min3(r_vx[0], r_vx[1], r_vx[2]);
        w_ymin     = min3(r_vy[0], r_vy[1], r_vy[2]);
        w_xmax_raw = max3(r_vx[0], r_vx[1], r_vx[2]);
        w_ymax_raw = max3(r_vy[0], r_vy[1], r_vy[2]);
        w_xmax     = (w_xmax_raw > X_LIM) ? X_LIM : w_xmax_raw;
        w_ymax     = (w_ymax_raw > Y_LIM) ? Y_LIM : w_ymax_raw;
        w_dmin01   = (bus.in_v0_depth < bus.in_v1_depth) ? bus.in_v0_depth : bus.in_v1_depth;
        w_dmin     = (w_dmin01 < bus.in_v2_depth) ? w_dmin01 : bus.in_v2_depth;
    end

    for (genvar gi = 0; gi < 3; gi++) begin : g_edge
        localparam int GJ = (gi + 1) % 3;
        raster_edge_eval #(.COORD_W(COORD_W), .EW(EW)) u_edge (
            .clock      (clock),
            .reset      (reset),
            .i_xi       (r_vx[gi]),
            .i_yi       (r_vy[gi]),
            .i_xj       (r_vx[GJ]),
            .i_yj       (r_vy[GJ]),
            .i_x0       (r_xmin),
            .i_y0       (r_ymin),
            .i_neg      (w_neg),
            .i_load     (w_load),
            .i_step_x   (w_step_x),
            .i_step_row (w_step_row),
            .o_c        (w_c[gi]),
            .o_e        (w_e[gi])
        );
    end

    assign w_area     = w_c[0] + w_c[1] + w_c[2];
    assign w_neg      = w_area[EW-1];
    assign w_load     = (r_state == S_EDGES);
    assign w_inside   = ~w_e[0][EW-1] & ~w_e[1][EW-1] & ~w_e[2][EW-1];
    assign w_scanning = (r_state == S_SCAN) & ~r_scan_end;
    assign w_out_free = ~r_pix_valid | bus.in_pix_ready;
    // Only an inside candidate needs the output register; outside ones always move on.
    assign w_advance  = w_scanning & (~w_inside | w_out_free);
    assign w_row_end  = (r_x == r_xmax);
    assign w_last     = w_row_end & (r_y == r_ymax);
    assign w_step_x   = w_advance & ~w_row_end;
    assign w_step_row = w_advance & w_row_end & ~w_last;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_vx        <= '0;
            r_vy        <= '0;
            r_depth     <= '0;
            r_color     <= '0;
            r_xmin      <= '0;
            r_xmax      <= '0;
            r_ymin      <= '0;
            r_ymax      <= '0;
            r_x         <= '0;
            r_y         <= '0;
            r_scan_end  <= 1'b0;
            r_pix_valid <= 1'b0;
            r_tri_done  <= 1'b0;
            r_pix_x     <= '0;
            r_pix_y     <= '0;
            r_pix_depth <= '0;
            r_pix_color <= '0;
        end else begin
            r_tri_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.in_tri_valid) begin
                        r_vx    <= {bus.in_v2_x, bus.in_v1_x, bus.in_v0_x};
                        r_vy    <= {bus.in_v2_y, bus.in_v1_y, bus.in_v0_y};
                        r_depth <= w_dmin;
                        r_color <= bus.in_color;
                        r_state <= S_BBOX;
                    end
                end
                S_BBOX: begin
                    r_xmin <= w_xmin;
                    r_xmax <= w_xmax;
                    r_ymin <= w_ymin;
                    r_ymax <= w_ymax;
                    r_x    <= w_xmin;
                    r_y    <= w_ymin;
                    if ((w_xmin > w_xmax) || (w_ymin > w_ymax)) begin
                        r_state    <= S_DONE;
                        r_tri_done <= 1'b1;
                    end else begin
                        r_state <= S_EDGES;
                    end
                end
                S_EDGES: begin
                    r_scan_end <= 1'b0;
                    if (w_area == '0) begin
                        r_state    <= S_DONE;
                        r_tri_done <= 1'b1;
                    end else begin
                        r_state <= S_SCAN;
                    end
                end
                S_SCAN: begin
                    if (r_scan_end) begin
                        // Whole bbox evaluated; wait for the last pixel to leave.
                        if (w_out_free) begin
                            r_pix_valid <= 1'b0;
                            r_state     <= S_DONE;
                            r_tri_done  <= 1'b1;
                        end
                    end else begin
                        if (w_advance && w_inside) begin
                            r_pix_valid <= 1'b1;
                            r_pix_x     <= r_x;
                            r_pix_y     <= r_y;
                            r_pix_depth <= r_depth;
                            r_pix_color <= r_color;
                        end else if (r_pix_valid && bus.in_pix_ready) begin
                            r_pix_valid <= 1'b0;
                        end
                        if (w_advance) begin
                            if (w_last) begin
                                if (!w_inside && w_out_free) begin
                                    r_state    <= S_DONE;
                                    r_tri_done <= 1'b1;
                                end else begin
                                    r_scan_end <= 1'b1;
                                end
                            end else if (w_row_end) begin
                                r_x <= r_xmin;
                                r_y <= r_y + 1'b1;
                            end else begin
                                r_x <= r_x + 1'b1;
                            end
                        end
                    end
                end
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.out_tri_ready   = (r_state == S_IDLE) & ~reset;
    assign bus.out_busy        = (r_state != S_IDLE);
    assign bus.out_tri_done    = r_tri_done;
    assign bus.out_pix_valid   = r_pix_valid;
    assign bus.out_pixel_x     = r_pix_x;
    assign bus.out_pixel_y     = r_pix_y;
    assign bus.out_pixel_depth = r_pix_depth;
    assign bus.out_pixel_color = r_pix_color;
endmodule

// File: tb/tb_edge_raster_engine.sv
// tb/tb_edge_raster_engine.sv - self-checking bench for edge_raster_engine
module tb_edge_raster_engine;
    localparam int CW = 16;
    localparam int DW = 2;
    localparam int KW = 16;
    localparam int SW = 640;
    localparam int SH = 480;

    typedef struct {
        int x;
        int y;
        int d;
        int c;
    } pix_t;

    typedef struct {
        int x0, y0, x1, y1, x2, y2;
        int d0, d1, d2;
        int color;
        int rmode;
        int exp_cnt;
    } tvec_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    edge_raster_engine_if #(.COORD_W(CW), .DEPTH_W(DW), .COLOR_W(KW)) bus ();

    edge_raster_engine #(
        .COORD_W(CW), .DEPTH_W(DW), .COLOR_W(KW), .SCREEN_W(SW), .SCREEN_H(SH)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int   n_checks = 0;
    int   n_errors = 0;
    int   n_pix    = 0;
    int   n_done   = 0;
    int   rmode    = 0;
    pix_t exp_q[$];
    pix_t e_pix;
    pix_t held;
    logic held_v = 1'b0;
    tvec_t vecs[5];

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Ready pattern: 0 = always ready, 1 = toggle every cycle, 2 = never ready.
    initial begin
        bus.in_pix_ready = 1'b1;
        forever begin
            @(posedge clock);
            #1;
            case (rmode)
                0:       bus.in_pix_ready = 1'b1;
                1:       bus.in_pix_ready = ~bus.in_pix_ready;
                default: bus.in_pix_ready = 1'b0;
            endcase
        end
    end

    // Scoreboard: pops on every transfer, checks stability over stall cycles.
    always @(negedge clock) begin
        if (reset) begin
            held_v = 1'b0;
        end else begin
            if (bus.out_tri_done) n_done++;
            if (held_v) begin
                check("stall_valid", bus.out_pix_valid, 1);
                check("stall_x", bus.out_pixel_x, held.x);
                check("stall_y", bus.out_pixel_y, held.y);
                check("stall_depth", bus.out_pixel_depth, held.d);
                check("stall_color", bus.out_pixel_color, held.c);
            end
            if (bus.out_pix_valid) begin
                if (bus.in_pix_ready) begin
                    n_pix++;
                    held_v = 1'b0;
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_errors++;
                        $display("FAIL extra_pixel: got x=%0d y=%0d, expected no pixel",
                                 bus.out_pixel_x, bus.out_pixel_y);
                    end else begin
                        e_pix = exp_q.pop_front();
                        check("pix_x", bus.out_pixel_x, e_pix.x);
                        check("pix_y", bus.out_pixel_y, e_pix.y);
                        check("pix_depth", bus.out_pixel_depth, e_pix.d);
                        check("pix_color", bus.out_pixel_color, e_pix.c);
                        check("pix_on_screen", (bus.out_pixel_x < SW) && (bus.out_pixel_y < SH), 1);
                    end
                end else begin
                    held_v = 1'b1;
                    held.x = bus.out_pixel_x;
                    held.y = bus.out_pixel_y;
                    held.d = bus.out_pixel_depth;
                    held.c = bus.out_pixel_color;
                end
            end else begin
                held_v = 1'b0;
            end
        end
    end

    // Reference: direct evaluation of the three edge functions at every bbox point.
    task automatic model_tri(input tvec_t v);
        int xs[3], ys[3];
        longint a[3], b[3], c[3], area, s, e;
        int xmin, xmax, ymin, ymax, dmin, j;
        bit in;
        pix_t p;
        xs = '{v.x0, v.x1, v.x2};
        ys = '{v.y0, v.y1, v.y2};
        xmin = xs[0]; xmax = xs[0]; ymin = ys[0]; ymax = ys[0];
        for (int i = 1; i < 3; i++) begin
            if (xs[i] < xmin) xmin = xs[i];
            if (xs[i] > xmax) xmax = xs[i];
            if (ys[i] < ymin) ymin = ys[i];
            if (ys[i] > ymax) ymax = ys[i];
        end
        if (xmax > SW - 1) xmax = SW - 1;
        if (ymax > SH - 1) ymax = SH - 1;
        dmin = v.d0;
        if (v.d1 < dmin) dmin = v.d1;
        if (v.d2 < dmin) dmin = v.d2;
        area = 0;
        for (int i = 0; i < 3; i++) begin
            j = (i + 1) % 3;
            a[i] = ys[i] - ys[j];
            b[i] = xs[j] - xs[i];
            c[i] = longint'(xs[i]) * ys[j] - longint'(xs[j]) * ys[i];
            area += c[i];
        end
        if (area == 0 || xmin > xmax || ymin > ymax) return;
        s = (area < 0) ? -1 : 1;
        for (int y = ymin; y <= ymax; y++) begin
            for (int x = xmin; x <= xmax; x++) begin
                in = 1'b1;
                for (int i = 0; i < 3; i++) begin
                    e = s * (a[i] * x + b[i] * y + c[i]);
                    if (e < 0) in = 1'b0;
                end
                if (in) begin
                    p.x = x; p.y = y; p.d = dmin; p.c = v.color;
                    exp_q.push_back(p);
                end
            end
        end
    endtask

    task automatic send_tri(input tvec_t v);
        int k;
        k = 0;
        @(negedge clock);
        while (!bus.out_tri_ready && k < 100) begin
            @(negedge clock);
            k++;
        end
        check("tri_ready_before_send", bus.out_tri_ready, 1);
        bus.in_v0_x = CW'(v.x0); bus.in_v0_y = CW'(v.y0);
        bus.in_v1_x = CW'(v.x1); bus.in_v1_y = CW'(v.y1);
        bus.in_v2_x = CW'(v.x2); bus.in_v2_y = CW'(v.y2);
        bus.in_v0_depth = DW'(v.d0); bus.in_v1_depth = DW'(v.d1); bus.in_v2_depth = DW'(v.d2);
        bus.in_color = KW'(v.color);
        bus.in_tri_valid = 1'b1;
        @(posedge clock);
        #1;
        bus.in_tri_valid = 1'b0;
    endtask

    task automatic run_vec(input tvec_t v, input int idx);
        int k;
        exp_q.delete();
        n_pix = 0;
        n_done = 0;
        rmode = v.rmode;
        model_tri(v);
        send_tri(v);
        k = 0;
        while (n_done == 0 && k < 3000) begin
            @(negedge clock);
            k++;
        end
        repeat (4) @(negedge clock);
        check($sformatf("v%0d_done_count", idx), n_done, 1);
        check($sformatf("v%0d_pix_count", idx), n_pix, v.exp_cnt);
        check($sformatf("v%0d_missing_pixels", idx), exp_q.size(), 0);
        check($sformatf("v%0d_busy_after", idx), bus.out_busy, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, k;
        tvec_t t;
        bus.in_tri_valid = 1'b0;
        bus.in_v0_x = '0; bus.in_v0_y = '0; bus.in_v1_x = '0;
        bus.in_v1_y = '0; bus.in_v2_x = '0; bus.in_v2_y = '0;
        bus.in_v0_depth = '0; bus.in_v1_depth = '0; bus.in_v2_depth = '0;
        bus.in_color = '0;

        vecs[0] = '{0, 0, 4, 0, 0, 4, 2, 1, 3, 'hA5C3, 0, 15};
        vecs[1] = '{0, 0, 0, 4, 4, 0, 2, 1, 3, 'h1234, 0, 15};
        vecs[2] = '{0, 0, 4, 0, 0, 4, 3, 2, 2, 'h5A5A, 1, 15};
        vecs[3] = '{630, 0, 700, 0, 630, 10, 3, 3, 2, 'hFFFF, 0, 99};
        vecs[4] = '{0, 470, 8, 470, 0, 500, 3, 1, 2, 'h0F0F, 1, 73};

        repeat (3) @(posedge clock);
        #1;
        check("reset_tri_ready", bus.out_tri_ready, 0);
        check("reset_pix_valid", bus.out_pix_valid, 0);
        check("reset_busy", bus.out_busy, 0);
        check("reset_tri_done", bus.out_tri_done, 0);
        check("reset_pixel_x", bus.out_pixel_x, 0);
        check("reset_pixel_color", bus.out_pixel_color, 0);
        @(negedge clock);
        reset = 1'b0;
        @(posedge clock);
        #1;
        check("ready_after_reset", bus.out_tri_ready, 1);

        for (int i = 0; i < 5; i++) run_vec(vecs[i], i);

        // Degenerate (collinear) triangle: no pixels, done within 3 cycles of accept.
        rmode = 0;
        n_pix = 0;
        exp_q.delete();
        t = '{10, 10, 20, 20, 30, 30, 1, 1, 1, 'h0001, 0, 0};
        send_tri(t);
        lat = 0;
        while (!bus.out_tri_done && lat < 10) begin
            @(negedge clock);
            lat++;
        end
        check("degenerate_done_within_3", (lat >= 1) && (lat <= 3), 1);
        repeat (4) @(negedge clock);
        check("degenerate_no_pixels", n_pix, 0);

        // Reset while a pixel is held in the output register.
        rmode = 2;
        exp_q.delete();
        send_tri(vecs[0]);
        k = 0;
        while (!bus.out_pix_valid && k < 50) begin
            @(negedge clock);
            k++;
        end
        check("t6_pixel_held", bus.out_pix_valid, 1);
        reset = 1'b1;
        @(posedge clock);
        #1;
        check("t6_valid_dropped", bus.out_pix_valid, 0);
        check("t6_busy_cleared", bus.out_busy, 0);
        check("t6_ready_low_in_reset", bus.out_tri_ready, 0);
        @(negedge clock);
        reset = 1'b0;
        exp_q.delete();
        @(posedge clock);
        #1;
        check("t6_ready_after_release", bus.out_tri_ready, 1);
        run_vec(vecs[0], 5);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
